mpu_matrix_engine: RTL and testbench

Parametrised, multi-cycle matrix arithmetic unit for the MPU. It generalises the fixed 5x5 / 8-bit operation selector to an N×N array of W-bit signed elements. It adds a start/busy/done handshake, a sequential matrix multiply (one output element per cycle), active-size masking, and error reporting. It sits between the MPU instruction decoder (which drives `start`, `operation` and the operands) and the result writeback path (which samples `result` on `done`).

---
 rtl/mpu_matrix_engine.sv | 198 +++++++++++++++++++
 tb/tb_mpu_matrix_engine.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mpu_matrix_engine.sv
// mpu_matrix_engine: N x N signed matrix arithmetic unit with a start/busy/done handshake.
// Elementwise ops (add, sub, scalar mul, opposite, transpose) complete in a single RUN cycle.
// Matrix multiply produces one output element per RUN cycle, in row-major order.
// Compile-time option MPU_SATURATE_EN: narrowing clamps to the W-bit signed range
// and raises a sticky overflow flag. Without it, narrowing wraps and overflow is tied to 0.
module mpu_matrix_engine #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       operation,
    input  logic [7:0]       size,
    input  logic [W-1:0]     factor,
    input  logic [N*N*W-1:0] matrix_a,
    input  logic [N*N*W-1:0] matrix_b,
    output logic [N*N*W-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             overflow
);

    // Holds a full dot product of N terms of W x W products with headroom.
    localparam int ACC_W = 2*W + $clog2(N) + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              op_q;
    logic [7:0]              size_q;
    logic signed [W-1:0]     factor_q;
    logic [N*N*W-1:0]        a_q, b_q;
    logic [7:0]              row, col;
    logic                    cmd_ok, is_mul, mul_last;
    logic [N*N*W-1:0]        ew_res;
    logic signed [W-1:0]     ew_a, ew_b, ew_t;
    logic signed [ACC_W-1:0] ew_wide;
    logic signed [W-1:0]     mul_a, mul_b, mul_elem;
    logic signed [ACC_W-1:0] mul_acc;

    function automatic logic signed [W-1:0] narrow(input logic signed [ACC_W-1:0] v);
`ifdef MPU_SATURATE_EN
        if (v > SAT_MAX) return SAT_MAX[W-1:0];
        if (v < SAT_MIN) return SAT_MIN[W-1:0];
        return v[W-1:0];
`else
        return v[W-1:0];
`endif
    endfunction

`ifdef MPU_SATURATE_EN
    logic ew_clip, mul_clip, ovf_q;

    function automatic logic clipped(input logic signed [ACC_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign cmd_ok   = (op_q != 3'd5) && (op_q != 3'd7) && (size_q != 8'd0) && (int'(size_q) <= N);
    assign is_mul   = (op_q == 3'd6);
    assign mul_last = (row == size_q - 8'd1) && (col == size_q - 8'd1);

    // Elementwise result for the whole array, masked to the active s x s corner.
    always_comb begin
        ew_res  = '0;
        ew_a    = '0;
        ew_b    = '0;
        ew_t    = '0;
        ew_wide = '0;
`ifdef MPU_SATURATE_EN
        ew_clip = 1'b0;
`endif
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ew_a = a_q[(r*N+c)*W +: W];
                ew_b = b_q[(r*N+c)*W +: W];
                ew_t = a_q[(c*N+r)*W +: W];
                case (op_q)
                    3'd0:    ew_wide = ACC_W'(ew_a) + ACC_W'(ew_b);
                    3'd1:    ew_wide = ACC_W'(ew_a) - ACC_W'(ew_b);
                    3'd2:    ew_wide = ACC_W'(ew_a) * ACC_W'(factor_q);
                    3'd3:    ew_wide = -ACC_W'(ew_a);
                    default: ew_wide = ACC_W'(ew_t);
                endcase
                if (r < int'(size_q) && c < int'(size_q)) begin
                    ew_res[(r*N+c)*W +: W] = narrow(ew_wide);
`ifdef MPU_SATURATE_EN
                    ew_clip = ew_clip | clipped(ew_wide);
`endif
                end
            end
        end
    end

    // Dot product of row `row` of A with column `col` of B over the active size.
    always_comb begin
        mul_acc = '0;
        mul_a   = '0;
        mul_b   = '0;
        for (int k = 0; k < N; k++) begin
            mul_a = a_q[(int'(row)*N+k)*W +: W];
            mul_b = b_q[(k*N+int'(col))*W +: W];
            if (k < int'(size_q))
                mul_acc = mul_acc + ACC_W'(mul_a) * ACC_W'(mul_b);
        end
        mul_elem = narrow(mul_acc);
`ifdef MPU_SATURATE_EN
        mul_clip = clipped(mul_acc);
`endif
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (!cmd_ok || !is_mul || mul_last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on accept; later input changes are ignored.
    always_ff @(posedge clock) begin
        if (state == IDLE && start) begin
            op_q     <= operation;
            size_q   <= size;
            factor_q <= factor;
            a_q      <= matrix_a;
            b_q      <= matrix_b;
        end
    end

    // Result, status flags and multiply element counters.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            result <= '0;
            error  <= 1'b0;
            row    <= '0;
            col    <= '0;
`ifdef MPU_SATURATE_EN
            ovf_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    error <= 1'b0;
                    row   <= '0;
                    col   <= '0;
`ifdef MPU_SATURATE_EN
                    ovf_q <= 1'b0;
`endif
                end
                RUN: begin
                    if (!cmd_ok) begin
                        error <= 1'b1;
                    end else if (is_mul) begin
                        // First element also clears the array so the masked area reads 0.
                        if (row == 8'd0 && col == 8'd0) result <= '0;
                        result[(int'(row)*N+int'(col))*W +: W] <= mul_elem;
`ifdef MPU_SATURATE_EN
                        ovf_q <= ovf_q | mul_clip;
`endif
                        if (col == size_q - 8'd1) begin
                            col <= '0;
                            row <= row + 8'd1;
                        end else begin
                            col <= col + 8'd1;
                        end
                    end else begin
                        result <= ew_res;
`ifdef MPU_SATURATE_EN
                        ovf_q <= ovf_q | ew_clip;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_matrix_engine.sv
// Directed, table-driven bench for mpu_matrix_engine (N=5, W=8).
module tb_mpu_matrix_engine;

    localparam int N  = 5;
    localparam int W  = 8;
    localparam int MW = N*N*W;

    logic          clock = 1'b0;
    logic          reset_n, start;
    logic [2:0]    operation;
    logic [7:0]    size;
    logic [W-1:0]  factor;
    logic [MW-1:0] matrix_a, matrix_b, result;
    logic          busy, done, error, overflow;

    int n_cmp = 0;
    int n_bad = 0;
    logic [MW-1:0] last_exp;

    always #5 clock = ~clock;

    mpu_matrix_engine #(.N(N), .W(W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .operation(operation),
        .size(size), .factor(factor), .matrix_a(matrix_a), .matrix_b(matrix_b),
        .result(result), .busy(busy), .done(done), .error(error), .overflow(overflow)
    );

    typedef struct {
        string         name;
        logic [2:0]    op;
        logic [7:0]    s;
        logic [W-1:0]  f;
        logic [MW-1:0] a, b, res;
        logic          err, ovf;
        int            lat;
        bit            keep, poke;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Matrix with only the top-left 2x2 corner populated.
    function automatic logic [MW-1:0] mk2(input int e00, input int e01, input int e10, input int e11);
        logic [MW-1:0] m;
        m = '0;
        m[0*W +: W]     = W'(e00);
        m[1*W +: W]     = W'(e01);
        m[N*W +: W]     = W'(e10);
        m[(N+1)*W +: W] = W'(e11);
        return m;
    endfunction

    function automatic vec_t mkv(input string nm, input int op, input int s, input int f,
                                 input logic [MW-1:0] a, input logic [MW-1:0] b,
                                 input logic [MW-1:0] res, input bit err, input bit ovf,
                                 input int lat, input bit keep, input bit poke);
        vec_t v;
        v.name = nm; v.op = 3'(op); v.s = 8'(s); v.f = W'(f);
        v.a = a; v.b = b; v.res = res; v.err = err; v.ovf = ovf;
        v.lat = lat; v.keep = keep; v.poke = poke;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int n;
        bit got;
        logic [MW-1:0] exp;
        @(negedge clock);
        operation = v.op; size = v.s; factor = v.f;
        matrix_a = v.a; matrix_b = v.b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        // Scramble the live inputs: the engine must work from its latched copy.
        matrix_a = ~v.a; matrix_b = {MW{1'b1}}; operation = 3'd3; size = 8'd1; factor = 8'h7f;
        chk({v.name, ".busy_after_accept"}, MW'(busy), MW'(1));
        n = 0; got = 0;
        while (!got && n < 60) begin
            @(posedge clock); #1;
            n++;
            if (done) got = 1;
            else if (v.poke && n == 1) start = 1'b1;
            else if (v.poke && n == 2) start = 1'b0;
        end
        start = 1'b0;
        chk({v.name, ".latency"}, MW'(n), MW'(v.lat));
        if (got) begin
            exp = v.keep ? last_exp : v.res;
            chk({v.name, ".result"},   result,        exp);
            chk({v.name, ".error"},    MW'(error),    MW'(v.err));
            chk({v.name, ".overflow"}, MW'(overflow), MW'(v.ovf));
            chk({v.name, ".busy"},     MW'(busy),     MW'(1));
            last_exp = exp;
            @(posedge clock); #1;
            chk({v.name, ".idle_after"}, MW'({busy, done}), MW'(0));
        end
    endtask

    initial begin
        logic [MW-1:0] ones, fives;
        int seen;
        ones  = {(N*N){8'h01}};
        fives = {(N*N){8'h05}};
        last_exp = '0;

        vecs.push_back(mkv("add", 0, 2, 0, mk2(1,2,3,4), mk2(10,20,30,40), mk2(11,22,33,44), 0, 0, 1, 0, 0));
        vecs.push_back(mkv("err_op5", 5, 2, 0, mk2(9,9,9,9), mk2(9,9,9,9), '0, 1, 0, 1, 1, 0));
        vecs.push_back(mkv("err_s6", 0, 6, 0, mk2(9,9,9,9), mk2(9,9,9,9), '0, 1, 0, 1, 1, 0));
        vecs.push_back(mkv("err_s0", 0, 0, 0, mk2(9,9,9,9), mk2(9,9,9,9), '0, 1, 0, 1, 1, 0));
        vecs.push_back(mkv("sub", 1, 2, 0, mk2(5,-3,0,7), mk2(2,4,-1,7), mk2(3,-7,1,0), 0, 0, 1, 0, 0));
        vecs.push_back(mkv("smul", 2, 2, -2, mk2(3,-4,5,0), '0, mk2(-6,8,-10,0), 0, 0, 1, 0, 0));
        vecs.push_back(mkv("opp", 3, 2, 0, mk2(1,-2,127,0), '0, mk2(-1,2,-127,0), 0, 0, 1, 0, 0));
        vecs.push_back(mkv("transp", 4, 2, 0, mk2(1,2,3,4), '0, mk2(1,3,2,4), 0, 0, 1, 0, 0));
        vecs.push_back(mkv("mask_add", 0, 1, 0, mk2(1,2,3,4), mk2(1,1,1,1), mk2(2,0,0,0), 0, 0, 1, 0, 0));
        vecs.push_back(mkv("mul2", 6, 2, 0, mk2(1,2,3,4), mk2(5,6,7,8), mk2(19,22,43,50), 0, 0, 4, 0, 1));
`ifdef MPU_SATURATE_EN
        vecs.push_back(mkv("ovf_add", 0, 1, 0, mk2(100,0,0,0), mk2(100,0,0,0), mk2(127,0,0,0), 0, 1, 1, 0, 0));
        vecs.push_back(mkv("ovf_opp", 3, 1, 0, mk2(-128,0,0,0), '0, mk2(127,0,0,0), 0, 1, 1, 0, 0));
        vecs.push_back(mkv("ovf_smul", 2, 1, 3, mk2(100,0,0,0), '0, mk2(127,0,0,0), 0, 1, 1, 0, 0));
        vecs.push_back(mkv("ovf_mul", 6, 2, 0, mk2(100,100,0,0), mk2(1,0,1,0), mk2(127,0,0,0), 0, 1, 4, 0, 0));
`else
        vecs.push_back(mkv("ovf_add", 0, 1, 0, mk2(100,0,0,0), mk2(100,0,0,0), mk2(-56,0,0,0), 0, 0, 1, 0, 0));
        vecs.push_back(mkv("ovf_opp", 3, 1, 0, mk2(-128,0,0,0), '0, mk2(-128,0,0,0), 0, 0, 1, 0, 0));
        vecs.push_back(mkv("ovf_smul", 2, 1, 3, mk2(100,0,0,0), '0, mk2(44,0,0,0), 0, 0, 1, 0, 0));
        vecs.push_back(mkv("ovf_mul", 6, 2, 0, mk2(100,100,0,0), mk2(1,0,1,0), mk2(-56,0,0,0), 0, 0, 4, 0, 0));
`endif
        vecs.push_back(mkv("mul5", 6, 5, 0, ones, ones, fives, 0, 0, 25, 0, 0));

        // Reset held for two edges with a pending add request.
        reset_n = 1'b0; start = 1'b1; operation = 3'd0; size = 8'd2; factor = '0;
        matrix_a = mk2(1,2,3,4); matrix_b = mk2(1,2,3,4);
        repeat (2) @(posedge clock);
        #1;
        chk("reset.busy",     MW'(busy),     MW'(0));
        chk("reset.done",     MW'(done),     MW'(0));
        chk("reset.result",   result,        '0);
        chk("reset.error",    MW'(error),    MW'(0));
        chk("reset.overflow", MW'(overflow), MW'(0));
        @(negedge clock);
        reset_n = 1'b1; start = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of a 5x5 multiply: no done, result cleared.
        @(negedge clock);
        operation = 3'd6; size = 8'd5; matrix_a = ones; matrix_b = ones; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        seen = 0;
        repeat (9) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("midreset.busy",   MW'(busy), MW'(0));
        chk("midreset.done",   MW'(done), MW'(0));
        chk("midreset.result", result,    '0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (30) begin
            @(posedge clock); #1;
            if (done) seen++;
        end
        chk("midreset.no_done", MW'(seen), MW'(0));
        last_exp = '0;

        // Recovery after the abandoned multiply.
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
